// File: rtl/replacement_policy_arbiter.sv
// ---------------------------------------------------------------------------
// replacement_policy_arbiter
//
// Lets N_REQ cache requesters share one replacement-policy line controller.
// A round-robin arbiter picks one request and latches its line address and
// its type (hit or miss). For one cycle it sends enable plus a hit or miss
// strobe to the controller. It then waits for ctrl_done_i and returns one
// response to the winning requester: the victim line on a miss, or the
// echoed line on a hit. If the controller never answers, the response
// carries an error flag instead.
//
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Every output is registered.
// Each output register is loaded from the next state, so the outputs change
// in the same cycle that the FSM enters the state that drives them.
//
// Ports
//   clock_i        clock
//   resetn_i       asynchronous reset, active low
//   req_i          per-requester request level, held until its ack
//   req_miss_i     per-requester type: 1 = miss, 0 = hit update
//   req_addr_i     per-requester line address, slice k = [k*BW +: BW]
//   ack_o          one-cycle pulse to the granted requester
//   resp_addr_o    victim line (miss) or echoed line (hit); holds until next RESP
//   resp_err_o     timeout flag; holds until next RESP
//   busy_o         FSM is not in IDLE
//   ctrl_enable_o  controller enable, high only in ISSUE
//   ctrl_addr_o    latched line address while a transaction is in flight
//   ctrl_hit_o     controller hit strobe, high only in ISSUE
//   ctrl_miss_o    controller miss strobe, high only in ISSUE
//   ctrl_done_i    controller ready / output valid
//   ctrl_addr_i    controller replacement pointer
// ---------------------------------------------------------------------------
module replacement_policy_arbiter #(
  parameter int N_REQ       = 2,
  parameter int N_LOCATIONS = 4,
  parameter int TIMEOUT     = 16,
  localparam int BW = (N_LOCATIONS > 1) ? $clog2(N_LOCATIONS) : 1
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      req_miss_i,
  input  logic [N_REQ*BW-1:0]   req_addr_i,
  output logic [N_REQ-1:0]      ack_o,
  output logic [BW-1:0]         resp_addr_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic                  ctrl_enable_o,
  output logic [BW-1:0]         ctrl_addr_o,
  output logic                  ctrl_hit_o,
  output logic                  ctrl_miss_o,
  input  logic                  ctrl_done_i,
  input  logic [BW-1:0]         ctrl_addr_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    grant_reg, grant_next;
  logic [BW-1:0]    addr_reg, addr_next;
  logic             miss_reg, miss_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]    wait_cnt_reg, wait_cnt_inc;
  logic             wait_expired;

  logic [N_REQ-1:0] ack_reg, ack_next;
  logic [BW-1:0]    resp_addr_reg, resp_addr_next;
  logic             resp_err_reg, resp_err_next;
  logic             busy_reg, busy_next;
  logic             ctrl_enable_reg, ctrl_enable_next;
  logic [BW-1:0]    ctrl_addr_reg, ctrl_addr_next;
  logic             ctrl_hit_reg, ctrl_hit_next;
  logic             ctrl_miss_reg, ctrl_miss_next;

  logic [BW-1:0]    req_addr_arr [N_REQ];
  logic [N_REQ-1:0] grant_onehot;
  logic             grant_found;
  logic [IW-1:0]    grant_idx;
  logic [IW:0]      cand;

  // Split the flat address bus into slices, and decode the latched grant
  // into the one-hot ack pattern.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_addr_arr[gi] = req_addr_i[gi*BW +: BW];
      assign grant_onehot[gi] = (grant_reg == IW'(gi));
    end
  endgenerate

  // Round-robin search: start at rr_ptr_reg, move upward, and wrap at N_REQ.
  // The candidate index is one bit wider than IW, so the wrap subtraction
  // also works when N_REQ is not a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!grant_found && req_i[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  assign rr_ptr_next  = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
  assign wait_cnt_inc = wait_cnt_reg + CW'(1);
  assign wait_expired = (wait_cnt_inc == CW'(TIMEOUT));

  // Request details are captured only at grant time. Later changes on the
  // requester inputs cannot affect a transaction that is already in flight.
  always_comb begin
    grant_next = grant_reg;
    addr_next  = addr_reg;
    miss_next  = miss_reg;
    if (state_reg == ST_IDLE && grant_found) begin
      grant_next = grant_idx;
      addr_next  = req_addr_arr[grant_idx];
      miss_next  = req_miss_i[grant_idx];
    end
  end

  // FSM state register
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (grant_found) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (ctrl_done_i || wait_expired) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM output logic. It is decoded from the next state so that the output
  // registers line up with the state that owns them.
  always_comb begin
    ctrl_enable_next = (state_next == ST_ISSUE);
    ctrl_hit_next    = (state_next == ST_ISSUE) && !miss_next;
    ctrl_miss_next   = (state_next == ST_ISSUE) && miss_next;
    ctrl_addr_next   = (state_next != ST_IDLE) ? addr_next : '0;
    busy_next        = (state_next != ST_IDLE);
    ack_next         = (state_next == ST_RESP) ? grant_onehot : '0;
    resp_addr_next   = resp_addr_reg;
    resp_err_next    = resp_err_reg;
    if (state_reg == ST_WAIT && state_next == ST_RESP) begin
      // If done and timeout happen in the same cycle, done wins.
      if (ctrl_done_i) begin
        resp_addr_next = miss_reg ? ctrl_addr_i : addr_reg;
        resp_err_next  = 1'b0;
      end else begin
        resp_addr_next = '0;
        resp_err_next  = 1'b1;
      end
    end
  end

  // Latched request, round-robin pointer and WAIT-cycle counter
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      grant_reg    <= '0;
      addr_reg     <= '0;
      miss_reg     <= 1'b0;
      rr_ptr_reg   <= '0;
      wait_cnt_reg <= '0;
    end else begin
      grant_reg <= grant_next;
      addr_reg  <= addr_next;
      miss_reg  <= miss_next;
      if (state_reg == ST_IDLE && grant_found) begin
        rr_ptr_reg <= rr_ptr_next;
      end
      case (state_reg)
        ST_WAIT: wait_cnt_reg <= wait_cnt_inc;
        ST_RESP: wait_cnt_reg <= '0;
        default: wait_cnt_reg <= wait_cnt_reg;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ack_reg         <= '0;
      resp_addr_reg   <= '0;
      resp_err_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      ctrl_enable_reg <= 1'b0;
      ctrl_addr_reg   <= '0;
      ctrl_hit_reg    <= 1'b0;
      ctrl_miss_reg   <= 1'b0;
    end else begin
      ack_reg         <= ack_next;
      resp_addr_reg   <= resp_addr_next;
      resp_err_reg    <= resp_err_next;
      busy_reg        <= busy_next;
      ctrl_enable_reg <= ctrl_enable_next;
      ctrl_addr_reg   <= ctrl_addr_next;
      ctrl_hit_reg    <= ctrl_hit_next;
      ctrl_miss_reg   <= ctrl_miss_next;
    end
  end

  assign ack_o         = ack_reg;
  assign resp_addr_o   = resp_addr_reg;
  assign resp_err_o    = resp_err_reg;
  assign busy_o        = busy_reg;
  assign ctrl_enable_o = ctrl_enable_reg;
  assign ctrl_addr_o   = ctrl_addr_reg;
  assign ctrl_hit_o    = ctrl_hit_reg;
  assign ctrl_miss_o   = ctrl_miss_reg;

endmodule

// File: tb/tb_replacement_policy_arbiter.sv
// ---------------------------------------------------------------------------
// tb_replacement_policy_arbiter
//
// Directed bench for replacement_policy_arbiter with N_REQ=2, N_LOCATIONS=4
// and TIMEOUT=16. The stimulus block pushes each expected response into a
// scoreboard queue when it drives the request. A monitor pops the queue on
// every ack pulse and prints one line for each transaction. The stimulus
// block also checks controller strobes, latency and reset behaviour at
// fixed cycles.
// ---------------------------------------------------------------------------
module tb_replacement_policy_arbiter;

  localparam int N_REQ       = 2;
  localparam int N_LOCATIONS = 4;
  localparam int TIMEOUT     = 16;
  localparam int BW          = 2;

  logic                clock_i;
  logic                resetn_i;
  logic [N_REQ-1:0]    req_i;
  logic [N_REQ-1:0]    req_miss_i;
  logic [N_REQ*BW-1:0] req_addr_i;
  logic [N_REQ-1:0]    ack_o;
  logic [BW-1:0]       resp_addr_o;
  logic                resp_err_o;
  logic                busy_o;
  logic                ctrl_enable_o;
  logic [BW-1:0]       ctrl_addr_o;
  logic                ctrl_hit_o;
  logic                ctrl_miss_o;
  logic                ctrl_done_i;
  logic [BW-1:0]       ctrl_addr_i;

  typedef struct packed {
    logic [N_REQ-1:0] ack;
    logic [BW-1:0]    addr;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   n_txn        = 0;

  replacement_policy_arbiter #(
    .N_REQ       (N_REQ),
    .N_LOCATIONS (N_LOCATIONS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clock_i       (clock_i),
    .resetn_i      (resetn_i),
    .req_i         (req_i),
    .req_miss_i    (req_miss_i),
    .req_addr_i    (req_addr_i),
    .ack_o         (ack_o),
    .resp_addr_o   (resp_addr_o),
    .resp_err_o    (resp_err_o),
    .busy_o        (busy_o),
    .ctrl_enable_o (ctrl_enable_o),
    .ctrl_addr_o   (ctrl_addr_o),
    .ctrl_hit_o    (ctrl_hit_o),
    .ctrl_miss_o   (ctrl_miss_o),
    .ctrl_done_i   (ctrl_done_i),
    .ctrl_addr_i   (ctrl_addr_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push_exp(input logic [N_REQ-1:0] a, input logic [BW-1:0] r, input logic e);
    exp_t x;
    x.ack  = a;
    x.addr = r;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // Call only while the DUT is in IDLE. The task drives the request, waits
  // (bounded) for the ack, checks the latency and then returns to IDLE.
  task automatic run_txn(input string tag, input logic [N_REQ-1:0] rq,
                         input logic [N_REQ-1:0] ms, input logic [N_REQ*BW-1:0] ad,
                         input logic [N_REQ-1:0] e_ack, input logic [BW-1:0] e_addr,
                         input logic e_err, input int e_lat);
    int lat;
    lat        = 0;
    req_i      = rq;
    req_miss_i = ms;
    req_addr_i = ad;
    push_exp(e_ack, e_addr, e_err);
    do begin
      tick();
      lat++;
    end while (ack_o === '0 && lat < 40);
    check({tag, "_latency"}, lat, e_lat);
    req_i = '0;
    tick();
  endtask

  // Scoreboard monitor: each ack pulse consumes one expected response.
  always @(posedge clock_i) begin
    #1;
    if (ack_o !== '0) begin
      n_txn++;
      if (sb_q.size() == 0) begin
        check("unexpected_ack", ack_o, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_ack", ack_o, mon_e.ack);
        check("sb_resp_addr", resp_addr_o, mon_e.addr);
        check("sb_resp_err", resp_err_o, mon_e.err);
        $display("txn %0d: ack=%b resp_addr=%0d resp_err=%0b (expected ack=%b addr=%0d err=%0b)",
                 n_txn, ack_o, resp_addr_o, resp_err_o, mon_e.ack, mon_e.addr, mon_e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no finish expected=finish by 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn_i    = 1'b0;
    req_i       = '0;
    req_miss_i  = '0;
    req_addr_i  = '0;
    ctrl_done_i = 1'b0;
    ctrl_addr_i = '0;
    repeat (2) tick();

    // Reset state
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_enable", ctrl_enable_o, 0);
    check("rst_hit", ctrl_hit_o, 0);
    check("rst_miss", ctrl_miss_o, 0);
    check("rst_ctrl_addr", ctrl_addr_o, 0);
    check("rst_resp_addr", resp_addr_o, 0);
    check("rst_resp_err", resp_err_o, 0);
    resetn_i = 1'b1;
    tick();
    check("idle_busy", busy_o, 0);

    // 1: single miss from requester 0, done already high
    req_i       = 2'b01;
    req_miss_i  = 2'b01;
    req_addr_i  = {2'd0, 2'd2};
    ctrl_done_i = 1'b1;
    ctrl_addr_i = 2'd3;
    push_exp(2'b01, 2'd3, 1'b0);
    tick();
    check("t1_issue_enable", ctrl_enable_o, 1);
    check("t1_issue_miss", ctrl_miss_o, 1);
    check("t1_issue_hit", ctrl_hit_o, 0);
    check("t1_issue_addr", ctrl_addr_o, 2);
    check("t1_issue_busy", busy_o, 1);
    tick();
    check("t1_wait_enable", ctrl_enable_o, 0);
    check("t1_wait_miss", ctrl_miss_o, 0);
    tick();
    check("t1_ack_cycle", ack_o, 2'b01);
    req_i = '0;
    tick();
    check("t1_idle_busy", busy_o, 0);
    check("t1_idle_ack", ack_o, 0);
    check("t1_resp_hold", resp_addr_o, 3);

    // Reset again so that round-robin restarts at requester 0
    resetn_i = 1'b0;
    tick();
    resetn_i = 1'b1;
    tick();
    check("rst2_resp_addr", resp_addr_o, 0);

    // 2: both requesters hold hits; grants alternate every 4 cycles
    req_i      = 2'b11;
    req_miss_i = 2'b00;
    req_addr_i = {2'd2, 2'd1};
    push_exp(2'b01, 2'd1, 1'b0);
    push_exp(2'b10, 2'd2, 1'b0);
    push_exp(2'b01, 2'd1, 1'b0);
    push_exp(2'b10, 2'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_hit_%0d", k), ctrl_hit_o, 1);
      check($sformatf("t2_miss_%0d", k), ctrl_miss_o, 0);
      check($sformatf("t2_addr_%0d", k), ctrl_addr_o, (k % 2 == 1) ? 2 : 1);
      tick();
      tick();
      check($sformatf("t2_ack_%0d", k), ack_o, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k == 3) req_i = '0;
      tick();
    end

    // 3: controller never answers, so the request times out; the next request still works
    ctrl_done_i = 1'b0;
    run_txn("t3_timeout", 2'b01, 2'b01, {2'd0, 2'd3}, 2'b01, 2'd0, 1'b1, TIMEOUT + 2);
    ctrl_done_i = 1'b1;
    run_txn("t3_after", 2'b10, 2'b00, {2'd2, 2'd0}, 2'b10, 2'd2, 1'b0, 3);

    // 4: done stays low for 3 WAIT cycles, then goes high
    req_i       = 2'b10;
    req_miss_i  = 2'b10;
    req_addr_i  = 4'b0000;
    ctrl_done_i = 1'b0;
    ctrl_addr_i = 2'd1;
    push_exp(2'b10, 2'd1, 1'b0);
    tick();
    check("t4_issue_miss", ctrl_miss_o, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_wait_ack_%0d", k), ack_o, 0);
    end
    tick();
    ctrl_done_i = 1'b1;
    tick();
    check("t4_ack", ack_o, 2'b10);
    req_i = '0;
    tick();

    // 6: granted requester changes its address during WAIT
    req_i       = 2'b01;
    req_miss_i  = 2'b00;
    req_addr_i  = {2'd0, 2'd3};
    ctrl_done_i = 1'b0;
    push_exp(2'b01, 2'd3, 1'b0);
    tick();
    check("t6_issue_addr", ctrl_addr_o, 3);
    check("t6_issue_hit", ctrl_hit_o, 1);
    tick();
    req_addr_i = {2'd0, 2'd1};
    tick();
    check("t6_wait_addr", ctrl_addr_o, 3);
    ctrl_done_i = 1'b1;
    tick();
    check("t6_ack", ack_o, 2'b01);
    req_i = '0;
    tick();

    // 5: reset asserted during WAIT
    req_i       = 2'b11;
    req_miss_i  = 2'b00;
    req_addr_i  = {2'd2, 2'd1};
    ctrl_done_i = 1'b0;
    tick();
    check("t5_issue_addr_rr", ctrl_addr_o, 2);
    tick();
    tick();
    check("t5_wait_busy", busy_o, 1);
    resetn_i = 1'b0;
    #1;
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_enable", ctrl_enable_o, 0);
    check("t5_rst_hit", ctrl_hit_o, 0);
    check("t5_rst_addr", ctrl_addr_o, 0);
    check("t5_rst_ack", ack_o, 0);
    tick();
    tick();
    req_i    = '0;
    resetn_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t5_no_ack_%0d", k), ack_o, 0);
    end
    ctrl_done_i = 1'b1;
    run_txn("t5_first_grant", 2'b11, 2'b00, {2'd2, 2'd1}, 2'b01, 2'd1, 1'b0, 3);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
